// File: rtl/rptr_empty_sync_if.sv
// Read-port bundle for the async FIFO read-domain controller.
// slave  : seen by rptr_empty_sync (takes the write pointer and the read request, drives pointers and flags)
// master : seen by whatever drives the read port
interface rptr_empty_sync_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr_gray;
  logic          r_en;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          r_empty;
  logic          r_almost_empty;
  logic [AW:0]   r_level;
  logic          r_underflow;
  logic          r_sync_err;

  modport slave (
    input  wptr_gray, r_en,
    output rptr_gray, raddr, r_empty, r_almost_empty, r_level, r_underflow, r_sync_err
  );

  modport master (
    output wptr_gray, r_en,
    input  rptr_gray, raddr, r_empty, r_almost_empty, r_level, r_underflow, r_sync_err
  );
endinterface

// File: rtl/rptr_empty_sync.sv
// Async FIFO read-domain control: write-pointer synchroniser of SYNC_STAGES flops,
// binary/Gray read pointers, and registered empty / almost-empty / level / underflow.
// Optional build macro RPTR_GRAY_CHECK_EN adds a sticky flag that catches multi-bit
// steps of the synchronised write pointer; without it r_sync_err is tied low.
module rptr_empty_sync #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  rptr_empty_sync_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AE_LV = (AW+1)'(AE_LEVEL);

  logic [AW:0] r_sync [SYNC_STAGES];
  logic [AW:0] r_rbin;
  logic [AW:0] r_rgray;
  logic        r_empty;
  logic        r_almost_empty;
  logic [AW:0] r_level;
  logic        r_underflow;

  logic [AW:0] w_wsync;
  logic [AW:0] w_wbin;
  logic        w_rinc;
  logic [AW:0] w_rbin_next;
  logic [AW:0] w_rgray_next;
  logic [AW:0] w_level_next;

  // Plain flop chain bringing the Gray write pointer into r_clk; nothing between stages.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_wsync = r_sync[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of itself and every higher bit.
  always_comb begin
    w_wbin = '0;
    for (int k = 0; k <= AW; k++) w_wbin[k] = ^(w_wsync >> k);
  end

  // A read only advances the pointer when the registered empty says data is there.
  assign w_rinc       = bus.r_en & ~r_empty;
  assign w_rbin_next  = r_rbin + {{AW{1'b0}}, w_rinc};
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  assign w_level_next = w_wbin - w_rbin_next;

  // Pointers and flags all register from next-state values, so empty asserts on the
  // same edge that consumes the last entry.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin         <= '0;
      r_rgray        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_rbin         <= w_rbin_next;
      r_rgray        <= w_rgray_next;
      r_empty        <= (w_rgray_next == w_wsync);
      r_almost_empty <= (w_level_next <= AE_LV);
      r_level        <= w_level_next;
      r_underflow    <= bus.r_en & r_empty;
    end
  end

  assign bus.rptr_gray      = r_rgray;
  assign bus.raddr          = r_rbin[AW-1:0];
  assign bus.r_empty        = r_empty;
  assign bus.r_almost_empty = r_almost_empty;
  assign bus.r_level        = r_level;
  assign bus.r_underflow    = r_underflow;

`ifdef RPTR_GRAY_CHECK_EN
  logic [AW:0] r_wsync_prev;
  logic        r_sync_err;
  logic [AW:0] w_diff;

  assign w_diff = w_wsync ^ r_wsync_prev;

  // Sticky flag: more than one bit changed between consecutive synchronised values.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wsync_prev <= '0;
      r_sync_err   <= 1'b0;
    end else begin
      r_wsync_prev <= w_wsync;
      if ((w_diff & (w_diff - {{AW{1'b0}}, 1'b1})) != '0) r_sync_err <= 1'b1;
    end
  end

  assign bus.r_sync_err = r_sync_err;
`else
  assign bus.r_sync_err = 1'b0;
`endif
endmodule

// File: tb/tb_rptr_empty_sync.sv
// Bench for rptr_empty_sync. The reference model counts writes and reads as plain
// integers, keeps a history of the write count seen at each edge to model the
// synchroniser delay, and derives every expected output from those counts.
module tb_rptr_empty_sync;
  localparam int DEPTH = 8;
  localparam int S     = 2;
  localparam int AE    = 2;
  localparam int AW    = 3;

  logic r_clk = 1'b0;
  logic rst_n = 1'b0;

  rptr_empty_sync_if #(.DEPTH(DEPTH)) bus ();

  rptr_empty_sync #(.DEPTH(DEPTH), .SYNC_STAGES(S), .AE_LEVEL(AE)) dut (
    .r_clk (r_clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 r_clk = ~r_clk;

  int n_pass  = 0;
  int n_total = 0;

  int wcnt;
  int rcnt;
  int whist[$];
  bit m_err;
  bit m_under;

  localparam logic [14:0] RST_VEC = {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};

  function automatic logic [AW:0] g(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int m_level();
    return whist[S] - rcnt;
  endfunction

  function automatic logic [14:0] expv();
    int          lvl;
    logic [AW:0] lv;
    logic [AW:0] rb;
    bit          e;
    lvl = m_level();
    lv  = lvl[AW:0];
    rb  = rcnt[AW:0];
    e   = m_err;
`ifndef RPTR_GRAY_CHECK_EN
    e   = 1'b0;
`endif
    return {g(rcnt), rb[AW-1:0], lvl == 0, lvl <= AE, lv, m_under, e};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.rptr_gray, bus.raddr, bus.r_empty, bus.r_almost_empty,
            bus.r_level, bus.r_underflow, bus.r_sync_err};
  endfunction

  function automatic void model_reset();
    wcnt = 0;
    rcnt = 0;
    whist.delete();
    for (int i = 0; i < S + 2; i++) whist.push_back(0);
    m_err   = 1'b0;
    m_under = 1'b0;
  endfunction

  task automatic set_w(input int v);
    wcnt = v;
    bus.wptr_gray = g(v);
  endtask

  // One clock edge: model consumes the current inputs, then time moves to 1 after the edge.
  task automatic tick();
    m_under = bus.r_en && (m_level() == 0);
    if (bus.r_en && m_level() != 0) rcnt++;
    @(posedge r_clk);
    whist.push_front(wcnt);
    void'(whist.pop_back());
    if ($countones(g(whist[S]) ^ g(whist[S+1])) > 1) m_err = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge r_clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs() !== RST_VEC) $display("FAIL reset_async got %h exp %h", obs(), RST_VEC);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.wptr_gray = 4'($urandom);
      bus.r_en      = 1'($urandom);
      @(posedge r_clk);
      #1;
      n_total++;
      if (obs() !== RST_VEC) $display("FAIL reset_hold[%0d] got %h exp %h", i, obs(), RST_VEC);
      else n_pass++;
    end
    bus.r_en = 1'b0;
    model_reset();
    set_w(0);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    bus.r_en = 1'b0;
    set_w(1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL latency_edge%0d got %h exp %h", e, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (bus.r_level !== 4'd1 || bus.r_empty !== 1'b0 || bus.r_almost_empty !== 1'b1)
      $display("FAIL latency_final level=%0d empty=%b ae=%b exp 1/0/1",
               bus.r_level, bus.r_empty, bus.r_almost_empty);
    else n_pass++;
  endtask

  task automatic test_drain();
    test_reset();
    set_w(8);
    bus.r_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_total++;
    if (obs() !== expv()) $display("FAIL drain_settle got %h exp %h", obs(), expv());
    else n_pass++;
    bus.r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (bus.raddr !== 3'(i)) $display("FAIL drain_raddr[%0d] got %0d exp %0d", i, bus.raddr, i);
      else n_pass++;
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL drain[%0d] got %h exp %h", i, obs(), expv());
      else n_pass++;
    end
    bus.r_en = 1'b0;
    n_total++;
    if (bus.rptr_gray !== 4'b1100 || bus.r_empty !== 1'b1)
      $display("FAIL drain_end rptr_gray=%b empty=%b exp 1100/1", bus.rptr_gray, bus.r_empty);
    else n_pass++;
  endtask

  task automatic test_underflow();
    bus.r_en = 1'b1;
    tick();
    n_total++;
    if (obs() !== expv() || bus.r_underflow !== 1'b1)
      $display("FAIL underflow_pulse got %h exp %h", obs(), expv());
    else n_pass++;
    bus.r_en = 1'b0;
    tick();
    n_total++;
    if (obs() !== expv() || bus.r_underflow !== 1'b0)
      $display("FAIL underflow_clear got %h exp %h", obs(), expv());
    else n_pass++;
    bus.r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL underflow_b2b[%0d] got %h exp %h", i, obs(), expv());
      else n_pass++;
    end
    bus.r_en = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    for (int lap = 0; lap < 2; lap++) begin
      bus.r_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
        set_w(wcnt + 1);
        tick();
        n_total++;
        if (obs() !== expv()) $display("FAIL wrap_w[%0d.%0d] got %h exp %h", lap, i, obs(), expv());
        else n_pass++;
      end
      for (int i = 0; i < 3; i++) tick();
      bus.r_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        n_total++;
        if (obs() !== expv()) $display("FAIL wrap_r[%0d.%0d] got %h exp %h", lap, i, obs(), expv());
        else n_pass++;
      end
    end
    bus.r_en = 1'b0;
  endtask

  task automatic test_gray_check();
    logic exp_err;
    test_reset();
    set_w(2);
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL graychk_edge%0d got %h exp %h", e, obs(), expv());
      else n_pass++;
    end
`ifdef RPTR_GRAY_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    n_total++;
    if (bus.r_sync_err !== exp_err) $display("FAIL graychk_set got %b exp %b", bus.r_sync_err, exp_err);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) set_w(wcnt + 1);
      bus.r_en = (i >= 2);
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL graychk_hold[%0d] got %h exp %h", i, obs(), expv());
      else n_pass++;
    end
    bus.r_en = 1'b0;
    test_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) test_reset();
      bus.r_en = 1'($urandom);
      if ($urandom_range(0, 1) == 1 && (wcnt - rcnt) < DEPTH) set_w(wcnt + 1);
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL random[%0d] got %h exp %h", i, obs(), expv());
      else n_pass++;
    end
    bus.r_en = 1'b0;
  endtask

  initial begin
    bus.wptr_gray = '0;
    bus.r_en      = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_drain();
    test_underflow();
    test_wrap();
    test_gray_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
